// File: rtl/bus_encoder_if.sv
// Bus-select request/response bundle between control and the bus encoder.
interface bus_encoder_if #(
  parameter int unsigned CNT_W = 8
);
  logic [31:0]      out_req;
  logic             hold;
  logic             err_clr;
  logic [4:0]       bus_signal;
  logic             bus_valid;
  logic             conflict;
  logic             rsvd_err;
  logic [CNT_W-1:0] conflict_count;
  logic             err_sticky;

  modport master (
    output out_req, hold, err_clr,
    input  bus_signal, bus_valid, conflict, rsvd_err, conflict_count, err_sticky
  );

  modport slave (
    input  out_req, hold, err_clr,
    output bus_signal, bus_valid, conflict, rsvd_err, conflict_count, err_sticky
  );
endinterface

// File: rtl/bus_encoder.sv
// Priority-encodes one-hot bus drive requests into a registered mux select, flagging conflicts.
// Latency 1 cycle, no comb path in->out; no backpressure, hold freezes select/count state.
module bus_encoder #(
  parameter logic [4:0]  IDLE_CODE = 5'd31,
  parameter logic [31:0] RSVD_MASK = 32'hFFC0_0000,
  parameter int unsigned CNT_W     = 8
) (
  input logic         clock,
  input logic         clear,
  bus_encoder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      legal;
  logic [3:0]       byte_any;
  logic [3:0][2:0]  byte_idx;
  logic [4:0]       enc_code;
  logic             legal_any;
  logic             multi_hit;
  logic             rsvd_hit;

  logic [4:0]       bus_signal_q;
  logic             bus_valid_q;
  logic             conflict_q;
  logic             rsvd_err_q;
  logic [CNT_W-1:0] conflict_count_q;
  logic             err_sticky_q;

  assign legal     = bus.out_req & ~RSVD_MASK;
  assign legal_any = |legal;
  assign rsvd_hit  = |(bus.out_req & RSVD_MASK);
  // Clearing the lowest set bit leaves something behind only if two or more were set.
  assign multi_hit = (legal & (legal - 32'd1)) != 32'd0;

  // Two-level encoder: lowest set bit inside each byte, then the lowest non-empty byte.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      byte_any[b] = |legal[b*8 +: 8];
      byte_idx[b] = 3'd0;
      for (int i = 7; i >= 0; i--) begin
        if (legal[b*8 + i]) begin
          byte_idx[b] = i[2:0];
        end
      end
    end
  end

  always_comb begin
    enc_code = IDLE_CODE;
    for (int b = 3; b >= 0; b--) begin
      if (byte_any[b]) begin
        enc_code = {b[1:0], byte_idx[b]};
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      bus_signal_q     <= IDLE_CODE;
      bus_valid_q      <= 1'b0;
      conflict_q       <= 1'b0;
      rsvd_err_q       <= 1'b0;
      conflict_count_q <= '0;
      err_sticky_q     <= 1'b0;
    end else if (bus.hold) begin
      conflict_q <= 1'b0;
      rsvd_err_q <= 1'b0;
      if (bus.err_clr) begin
        err_sticky_q <= 1'b0;
      end
    end else begin
      bus_signal_q <= legal_any ? enc_code : IDLE_CODE;
      bus_valid_q  <= legal_any;
      conflict_q   <= multi_hit;
      rsvd_err_q   <= rsvd_hit;
      if (multi_hit && (conflict_count_q != CNT_MAX)) begin
        conflict_count_q <= conflict_count_q + 1'b1;
      end
      // A new error on the same edge as err_clr keeps the flag set.
      if (multi_hit || rsvd_hit) begin
        err_sticky_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_sticky_q <= 1'b0;
      end
    end
  end

  assign bus.bus_signal     = bus_signal_q;
  assign bus.bus_valid      = bus_valid_q;
  assign bus.conflict       = conflict_q;
  assign bus.rsvd_err       = rsvd_err_q;
  assign bus.conflict_count = conflict_count_q;
  assign bus.err_sticky     = err_sticky_q;

endmodule

// File: tb/tb_bus_encoder.sv
// Randomized + directed scoreboard bench for bus_encoder against a behavioural model.
module tb_bus_encoder;
  localparam int unsigned CNT_W = 8;
  localparam logic [31:0] RSVD  = 32'hFFC0_0000;

  typedef struct {
    int sig;
    bit vld;
    bit conf;
    bit rsvd;
    int cnt;
    bit sticky;
  } exp_t;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  bus_encoder_if #(.CNT_W(CNT_W)) bus ();
  bus_encoder #(.CNT_W(CNT_W)) dut (.clock(clock), .clear(clear), .bus(bus));

  exp_t q[$];
  exp_t m;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic void model_reset();
    m.sig = 31; m.vld = 0; m.conf = 0; m.rsvd = 0; m.cnt = 0; m.sticky = 0;
  endfunction

  // Rule-level model: lowest legal requester wins, >=2 legal requesters is a conflict.
  function automatic void model_step(input logic [31:0] req, input bit h, input bit ec);
    logic [31:0] lg;
    int n;
    if (h) begin
      m.conf = 0;
      m.rsvd = 0;
      if (ec) m.sticky = 0;
    end else begin
      lg     = req & ~RSVD;
      n      = $countones(lg);
      m.conf = (n >= 2);
      m.rsvd = ((req & RSVD) != 0);
      m.vld  = (n > 0);
      m.sig  = 31;
      for (int i = 0; i < 32; i++) begin
        if (lg[i]) begin
          m.sig = i;
          break;
        end
      end
      if (m.conf && m.cnt < (1 << CNT_W) - 1) m.cnt++;
      if (m.conf || m.rsvd) m.sticky = 1;
      else if (ec) m.sticky = 0;
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clock);
      #1;
      if (!clear) begin
        model_reset();
        q.delete();
      end else begin
        model_step(bus.out_req, bus.hold, bus.err_clr);
        q.push_back(m);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (clear && q.size() > 0) begin
        e = q.pop_front();
        chk("bus_signal",     32'(bus.bus_signal),     32'(e.sig));
        chk("bus_valid",      32'(bus.bus_valid),      32'(e.vld));
        chk("conflict",       32'(bus.conflict),       32'(e.conf));
        chk("rsvd_err",       32'(bus.rsvd_err),       32'(e.rsvd));
        chk("conflict_count", 32'(bus.conflict_count), 32'(e.cnt));
        chk("err_sticky",     32'(bus.err_sticky),     32'(e.sticky));
      end
    end
  end

  task automatic drive(input logic [31:0] req, input bit h, input bit ec);
    @(negedge clock);
    bus.out_req = req;
    bus.hold    = h;
    bus.err_clr = ec;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_bus_signal"}, 32'(bus.bus_signal),     32'd31);
    chk({tag, "_bus_valid"},  32'(bus.bus_valid),      32'd0);
    chk({tag, "_conflict"},   32'(bus.conflict),       32'd0);
    chk({tag, "_rsvd_err"},   32'(bus.rsvd_err),       32'd0);
    chk({tag, "_count"},      32'(bus.conflict_count), 32'd0);
    chk({tag, "_sticky"},     32'(bus.err_sticky),     32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int mode;
    bus.out_req = '0;
    bus.hold    = 1'b0;
    bus.err_clr = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clock);
    clear = 1'b1;

    drive(32'h0000_0010, 0, 0);
    drive(32'h0, 0, 0);
    drive(32'h0010_0000, 0, 0);
    drive(32'h0020_0000, 0, 0);
    drive(32'h0080_0000, 0, 0);
    drive(32'h0, 0, 0);
    drive(32'h0008_0004, 0, 0);
    drive(32'h0, 0, 1);
    drive(32'h0, 0, 0);
    drive(32'h0040_0000, 0, 0);
    drive(32'h8000_0002, 0, 0);
    drive(32'h0, 0, 1);
    drive(32'h0000_0010, 0, 0);
    drive(32'h0000_0003, 1, 0);
    drive(32'h0000_0003, 1, 0);
    drive(32'h0000_0003, 0, 0);
    drive(32'h0, 1, 1);
    drive(32'h0000_0003, 0, 1);
    drive(32'h0, 0, 0);

    repeat (400) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0:       r = 32'h0;
        1:       r = 32'h1 << $urandom_range(0, 31);
        2:       r = (32'h1 << $urandom_range(0, 23)) | (32'h1 << $urandom_range(0, 31));
        default: r = $urandom;
      endcase
      drive(r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
    end

    repeat (300) drive(32'h0000_0003, 0, 0);
    @(negedge clock);
    #1;
    chk("sat_count", 32'(bus.conflict_count), 32'd255);
    clear = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    drive(32'h0000_0010, 0, 0);
    drive(32'h0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
